mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single main-memory port between the instruction-cache fill path and the data-cache fill/write-back path of the pipelined processor. It serializes one access at a time, gives the data side priority, and includes a bounded anti-starvation rule for the instruction side. It sits between the two cache controllers and the main memory, inside the processor top level. Its grant pulses feed the bench's ICacheReq/DCacheReq hookups.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/arb_pick.sv | 57 +++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg
//  Shared types and constants for the two-requester memory arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Default widths
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 3;

  // Grant ids latched with each access
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  mem_arbiter_if
//  Bundles the I-side, D-side and main-memory signals of the arbiter.
//  slave  : arbiter view.  master : requesters + memory view.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // I-side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  // D-side
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  // Main memory
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  // Status
  logic              i_grant;
  logic              d_grant;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    output i_done, i_rdata, d_done, d_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output i_grant, d_grant, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    input  i_done, i_rdata, d_done, d_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  i_grant, d_grant, busy
  );

endinterface

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
//  arb_pick
//  Winner select (D priority) with a saturating starvation counter that
//  forces the I side ahead after STARVE_MAX consecutive D wins.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_req_i,
  input  wire logic d_req_i,
  input  wire logic take_i,   // an access is being latched this cycle
  output logic      win_o
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             at_max;

  assign at_max = (starve_cnt_q == CNT_MAX);

  // D wins whenever it asks, unless I is waiting and has been starved long enough
  assign win_o = (d_req_i && !(i_req_i && at_max)) ? GNT_D : GNT_I;

  // Starvation counter next state: clear on I win, count D wins while I waits
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (take_i) begin
      if (win_o == GNT_I) begin
        starve_cnt_d = '0;
      end else if (i_req_i && !at_max) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter
//  Serializes I-cache fills and D-cache fills/write-backs onto one memory
//  port: IDLE -> ISSUE -> WAIT -> RESP, one access outstanding at a time.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_q,   state_d;
  logic              id_q,      id_d;
  logic              wr_q,      wr_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic pick_take;
  logic pick_win;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .i_req_i (bus.i_req),
    .d_req_i (bus.d_req),
    .take_i  (pick_take),
    .win_o   (pick_win)
  );

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      id_q      <= GNT_I;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state, winner latching and read-data capture
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_take = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          pick_take = 1'b1;
          id_d      = pick_win;
          if (pick_win == GNT_D) begin
            wr_d    = bus.d_wr;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            wr_d    = 1'b0;
            addr_d  = bus.i_addr;
            wdata_d = '0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_done) begin
          if (id_q == GNT_I) begin
            i_rdata_d = bus.mem_rdata;
          end else if (!wr_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_grant   = (state_q == ISSUE) && (id_q == GNT_I);
  assign bus.d_grant   = (state_q == ISSUE) && (id_q == GNT_D);
  assign bus.i_done    = (state_q == RESP)  && (id_q == GNT_I);
  assign bus.d_done    = (state_q == RESP)  && (id_q == GNT_D);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter
//  Self-checking bench: scoreboard of expected memory accesses plus
//  scenario tasks for reads, writes, starvation, reset abort, back-to-back
//  and spurious mem_done.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 3;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          id;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  acc_t          exp_q[$];
  acc_t          obs_q[$];
  int            n_vec   = 0;
  int            n_miss  = 0;
  int            cyc     = 0;
  int            mem_cd  = 0;
  int            mem_lat = 1;
  int            md_cyc  = -1;
  logic [DW-1:0] mem_val = '0;

  // One clock: advance past the edge, then run the memory responder model
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_done = 1'b0;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = mem_val;
        md_cyc        = cyc;
      end
    end
    if (bus.mem_en === 1'b1) begin
      mem_cd = mem_lat;
      obs_q.push_back(acc_t'({bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_grant}));
    end
  endtask

  // Tick until a done pulse or the budget runs out
  task automatic wait_done(input int max, output logic gi, output logic gd, output int n);
    gi = 1'b0;
    gd = 1'b0;
    for (n = 0; n < max; n++) begin
      tick();
      if (bus.i_done === 1'b1 || bus.d_done === 1'b1) begin
        gi = bus.i_done;
        gd = bus.d_done;
        n++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({bus.i_done, bus.d_done, bus.mem_en, bus.mem_wr, bus.i_grant, bus.d_grant, bus.busy} !== 7'b0) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {bus.i_done, bus.d_done, bus.mem_en, bus.mem_wr, bus.i_grant, bus.d_grant, bus.busy});
    end
    n_vec++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      n_miss++;
      $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata});
    end
    n_vec++;
    if (int'(dut.u_pick.starve_cnt_q) !== 0) begin
      n_miss++;
      $display("FAIL reset_starve: got %0d want 0", dut.u_pick.starve_cnt_q);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_idle: busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_i_read();
    logic gi, gd;
    int   n, en_cyc;
    acc_t e, o;
    obs_q.delete(); exp_q.delete();
    mem_lat = 2; mem_val = 16'h1234;
    bus.i_addr = 16'h0010; bus.i_req = 1'b1;
    exp_q.push_back(acc_t'({1'b0, 16'h0010, 16'h0000, GNT_I}));
    tick();
    en_cyc = cyc;
    n_vec++;
    if ({bus.i_grant, bus.d_grant, bus.mem_en} !== 3'b101) begin
      n_miss++;
      $display("FAIL i_read_grant: got %b want 101", {bus.i_grant, bus.d_grant, bus.mem_en});
    end
    n_vec++;
    if (obs_q.size() == 0) begin
      n_miss++;
      $display("FAIL i_read_access: got none want %h", exp_q[0]);
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        n_miss++;
        $display("FAIL i_read_access: got %h want %h", o, e);
      end
    end
    wait_done(20, gi, gd, n);
    bus.i_req = 1'b0;
    n_vec++;
    if ({gi, gd} !== 2'b10) begin
      n_miss++;
      $display("FAIL i_read_done: got i/d %b want 10", {gi, gd});
    end
    n_vec++;
    if (cyc - en_cyc !== mem_lat + 1) begin
      n_miss++;
      $display("FAIL i_read_latency: got %0d want %0d", cyc - en_cyc, mem_lat + 1);
    end
    n_vec++;
    if (bus.i_rdata !== 16'h1234) begin
      n_miss++;
      $display("FAIL i_read_rdata: got %h want 1234", bus.i_rdata);
    end
    tick();
  endtask

  task automatic test_d_read();
    logic gi, gd;
    int   n;
    acc_t e, o;
    obs_q.delete(); exp_q.delete();
    mem_lat = 1; mem_val = 16'h5A5A;
    bus.d_addr = 16'h0040; bus.d_wr = 1'b0; bus.d_wdata = 16'h0000; bus.d_req = 1'b1;
    exp_q.push_back(acc_t'({1'b0, 16'h0040, 16'h0000, GNT_D}));
    tick();
    n_vec++;
    if (obs_q.size() == 0) begin
      n_miss++;
      $display("FAIL d_read_access: got none want %h", exp_q[0]);
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        n_miss++;
        $display("FAIL d_read_access: got %h want %h", o, e);
      end
    end
    wait_done(20, gi, gd, n);
    bus.d_req = 1'b0;
    n_vec++;
    if ({gi, gd, bus.d_rdata, bus.i_rdata} !== {2'b01, 16'h5A5A, 16'h1234}) begin
      n_miss++;
      $display("FAIL d_read_done: got %b %h %h want 01 5a5a 1234", {gi, gd}, bus.d_rdata, bus.i_rdata);
    end
    tick();
  endtask

  task automatic test_d_write();
    logic gi, gd;
    int   n;
    acc_t e, o;
    obs_q.delete(); exp_q.delete();
    mem_lat = 1; mem_val = 16'hDEAD;
    bus.d_addr = 16'h0020; bus.d_wr = 1'b1; bus.d_wdata = 16'hBEEF; bus.d_req = 1'b1;
    exp_q.push_back(acc_t'({1'b1, 16'h0020, 16'hBEEF, GNT_D}));
    tick();
    n_vec++;
    if ({bus.mem_en, bus.mem_wr, bus.d_grant, bus.i_grant} !== 4'b1110) begin
      n_miss++;
      $display("FAIL d_write_issue: got %b want 1110", {bus.mem_en, bus.mem_wr, bus.d_grant, bus.i_grant});
    end
    n_vec++;
    if (obs_q.size() == 0) begin
      n_miss++;
      $display("FAIL d_write_access: got none want %h", exp_q[0]);
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        n_miss++;
        $display("FAIL d_write_access: got %h want %h", o, e);
      end
    end
    tick();
    n_vec++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {2'b01, 16'h0020, 16'hBEEF}) begin
      n_miss++;
      $display("FAIL d_write_hold: got %b %h %h want 01 0020 beef",
               {bus.mem_en, bus.mem_wr}, bus.mem_addr, bus.mem_wdata);
    end
    wait_done(20, gi, gd, n);
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    n_vec++;
    if ({gi, gd, bus.d_rdata} !== {2'b01, 16'h5A5A}) begin
      n_miss++;
      $display("FAIL d_write_done: got %b %h want 01 5a5a", {gi, gd}, bus.d_rdata);
    end
    tick();
  endtask

  task automatic test_starve();
    logic gi, gd, got, eid;
    int   n, mcnt;
    acc_t e, o;
    obs_q.delete(); exp_q.delete();
    mem_lat = 1; mem_val = 16'h0F0F; mcnt = 0;
    bus.i_addr = 16'h0100; bus.d_addr = 16'h0200; bus.d_wr = 1'b0; bus.d_wdata = 16'h0000;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      eid = (mcnt == SM) ? GNT_I : GNT_D;
      exp_q.push_back(acc_t'({1'b0, (eid == GNT_D) ? 16'h0200 : 16'h0100, 16'h0000, eid}));
      if (eid == GNT_I) mcnt = 0;
      else if (mcnt < SM) mcnt++;
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        tick();
        if (bus.mem_en === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      n_vec++;
      if (got !== 1'b1) begin
        n_miss++;
        $display("FAIL starve_issue[%0d]: got no mem_en want mem_en", k);
      end
      n_vec++;
      if ({bus.i_grant, bus.d_grant} !== ((eid == GNT_D) ? 2'b01 : 2'b10)) begin
        n_miss++;
        $display("FAIL starve_order[%0d]: got i/d %b want %s", k, {bus.i_grant, bus.d_grant},
                 (eid == GNT_D) ? "D" : "I");
      end
      n_vec++;
      if (int'(dut.u_pick.starve_cnt_q) !== mcnt) begin
        n_miss++;
        $display("FAIL starve_cnt[%0d]: got %0d want %0d", k, dut.u_pick.starve_cnt_q, mcnt);
      end
      n_vec++;
      if (obs_q.size() == 0) begin
        n_miss++;
        $display("FAIL starve_access[%0d]: got none want %h", k, exp_q[0]);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_miss++;
          $display("FAIL starve_access[%0d]: got %h want %h", k, o, e);
        end
      end
      wait_done(10, gi, gd, n);
      if (k == 7) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
      n_vec++;
      if ({gi, gd} !== ((eid == GNT_D) ? 2'b01 : 2'b10)) begin
        n_miss++;
        $display("FAIL starve_done[%0d]: got i/d %b want %s", k, {gi, gd}, (eid == GNT_D) ? "D" : "I");
      end
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    logic gi, gd, seen;
    int   n;
    obs_q.delete(); exp_q.delete();
    mem_lat = 3; mem_val = 16'h9999;
    bus.i_addr = 16'h0060; bus.i_req = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus.busy, bus.mem_en} !== 2'b10) begin
      n_miss++;
      $display("FAIL rst_wait_pre: got busy/en %b want 10", {bus.busy, bus.mem_en});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({bus.i_done, bus.d_done, bus.mem_en, bus.mem_wr, bus.i_grant, bus.d_grant, bus.busy,
         bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 71'h0) begin
      n_miss++;
      $display("FAIL rst_wait_zero: got %b %h %h %h %h want all 0",
               {bus.i_done, bus.d_done, bus.mem_en, bus.mem_wr, bus.i_grant, bus.d_grant, bus.busy},
               bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    rst = 1'b1; bus.i_req = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (bus.i_done !== 1'b0 || bus.d_done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if ({seen, bus.i_rdata} !== {1'b0, 16'h0000}) begin
      n_miss++;
      $display("FAIL rst_wait_late_done: got activity %b rdata %h want 0 0000", seen, bus.i_rdata);
    end
    obs_q.delete();
    mem_lat = 1; mem_val = 16'h7777;
    bus.i_addr = 16'h0050; bus.i_req = 1'b1;
    tick();
    n_vec++;
    if ({bus.i_grant, bus.mem_addr} !== {1'b1, 16'h0050}) begin
      n_miss++;
      $display("FAIL rst_wait_next_issue: got %b %h want 1 0050", bus.i_grant, bus.mem_addr);
    end
    wait_done(10, gi, gd, n);
    bus.i_req = 1'b0;
    n_vec++;
    if ({gi, gd, bus.i_rdata} !== {2'b10, 16'h7777}) begin
      n_miss++;
      $display("FAIL rst_wait_next_done: got %b %h want 10 7777", {gi, gd}, bus.i_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic gi, gd, got;
    int   n, first_md;
    obs_q.delete(); exp_q.delete();
    mem_lat = 1; mem_val = 16'h0BB0;
    bus.d_addr = 16'h0028; bus.d_wr = 1'b0; bus.d_req = 1'b1;
    wait_done(10, gi, gd, n);
    first_md = md_cyc;
    bus.d_addr = 16'h0030;
    n_vec++;
    if (gd !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_first_done: got %b want 1", gd);
    end
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (bus.mem_en === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if ({got, cyc - first_md} !== {1'b1, 32'd3}) begin
      n_miss++;
      $display("FAIL b2b_gap: got en %b gap %0d want 1 3", got, cyc - first_md);
    end
    n_vec++;
    if (bus.mem_addr !== 16'h0030) begin
      n_miss++;
      $display("FAIL b2b_addr: got %h want 0030", bus.mem_addr);
    end
    wait_done(10, gi, gd, n);
    bus.d_req = 1'b0;
    n_vec++;
    if ({gd, bus.d_rdata} !== {1'b1, 16'h0BB0}) begin
      n_miss++;
      $display("FAIL b2b_second_done: got %b %h want 1 0bb0", gd, bus.d_rdata);
    end
    tick();
  endtask

  task automatic test_spurious();
    logic gi, gd;
    int   n, en_cyc;
    obs_q.delete(); exp_q.delete();
    bus.mem_rdata = 16'hBAD0;
    bus.mem_done  = 1'b1;
    tick();
    n_vec++;
    if ({bus.busy, bus.i_done, bus.d_done, bus.mem_en} !== 4'b0) begin
      n_miss++;
      $display("FAIL spur_idle: got %b want 0000", {bus.busy, bus.i_done, bus.d_done, bus.mem_en});
    end
    mem_lat = 2; mem_val = 16'h4242;
    bus.i_addr = 16'h0070; bus.i_req = 1'b1;
    tick();
    en_cyc = cyc;
    bus.mem_rdata = 16'hBAD1;
    bus.mem_done  = 1'b1;
    tick();
    n_vec++;
    if ({bus.busy, bus.i_done, bus.d_done, bus.mem_en} !== 4'b1000) begin
      n_miss++;
      $display("FAIL spur_issue: got %b want 1000", {bus.busy, bus.i_done, bus.d_done, bus.mem_en});
    end
    wait_done(10, gi, gd, n);
    bus.i_req = 1'b0;
    n_vec++;
    if ({gi, cyc - en_cyc, bus.i_rdata} !== {1'b1, 32'd3, 16'h4242}) begin
      n_miss++;
      $display("FAIL spur_done: got %b lat %0d %h want 1 3 4242", gi, cyc - en_cyc, bus.i_rdata);
    end
    tick();
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_done = 1'b0;
    rst = 1'b0;
    test_reset();
    test_i_read();
    test_d_read();
    test_d_write();
    test_starve();
    test_reset_in_wait();
    test_back_to_back();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
